// File: rtl/fc_layer_scheduler.sv
// fc_layer_scheduler: steps the FC engine through up to MAX_LAYERS table entries.
// Ports:
//   clk, rst (async, active-low)
//   cfg_*      : layer table write port (honoured only in IDLE or ERROR)
//   run, run_layers, abort : chain control
//   busy, done, error, cur_layer : chain status
//   fc_start, fc_finish, fc_in, fc_out, weight_base, bias_base, bank_sel : engine side
module fc_layer_scheduler #(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_LAYERS = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_idx,
  input  logic [7:0]            cfg_fc_in,
  input  logic [7:0]            cfg_fc_out,
  input  logic [ADDR_WIDTH-1:0] cfg_w_base,
  input  logic [ADDR_WIDTH-1:0] cfg_b_base,
  input  logic                  run,
  input  logic [2:0]            run_layers,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            cur_layer,
  output logic                  fc_start,
  input  logic                  fc_finish,
  output logic [7:0]            fc_in,
  output logic [7:0]            fc_out,
  output logic [ADDR_WIDTH-1:0] weight_base,
  output logic [ADDR_WIDTH-1:0] bias_base,
  output logic                  bank_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t state, state_d;

  logic [7:0]            t_in [MAX_LAYERS];
  logic [7:0]            t_out[MAX_LAYERS];
  logic [ADDR_WIDTH-1:0] t_wb [MAX_LAYERS];
  logic [ADDR_WIDTH-1:0] t_bb [MAX_LAYERS];

  logic [15:0]           wd, wd_d;
  logic [2:0]            n_q, n_d;
  logic                  busy_d, done_d, error_d, start_d, bank_d;
  logic [1:0]            cur_d;
  logic [7:0]            in_d, out_d;
  logic [ADDR_WIDTH-1:0] wb_d, bb_d;
  logic                  run_ok, last;

  assign run_ok = run && !abort &&
                  (run_layers != 3'd0) &&
                  (run_layers <= 3'(MAX_LAYERS));
  assign last   = ({1'b0, cur_layer} == (n_q - 3'd1));

  always_comb begin
    state_d = state;
    busy_d  = busy;
    done_d  = 1'b0;
    error_d = error;
    start_d = 1'b0;
    cur_d   = cur_layer;
    bank_d  = bank_sel;
    in_d    = fc_in;
    out_d   = fc_out;
    wb_d    = weight_base;
    bb_d    = bias_base;
    wd_d    = wd;
    n_d     = n_q;
    if (abort && state != S_IDLE) begin
      // abort outranks every other transition, watchdog included
      state_d = S_IDLE;
      busy_d  = 1'b0;
      error_d = 1'b0;
      cur_d   = '0;
      bank_d  = 1'b0;
      in_d    = '0;
      out_d   = '0;
      wb_d    = '0;
      bb_d    = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (run_ok) begin
            state_d = S_LAUNCH;
            busy_d  = 1'b1;
            cur_d   = '0;
            bank_d  = 1'b0;
            n_d     = run_layers;
          end
        end
        S_LAUNCH: begin
          in_d    = t_in[cur_layer];
          out_d   = t_out[cur_layer];
          wb_d    = t_wb[cur_layer];
          bb_d    = t_bb[cur_layer];
          start_d = 1'b1;
          wd_d    = '0;
          state_d = S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          // fc_finish is high before launch; only its drop means "started"
          if (!fc_finish) begin
            state_d = S_WAIT_HIGH;
            wd_d    = '0;
          end else if (wd == WD_LAST) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            wd_d = wd + 16'd1;
          end
        end
        S_WAIT_HIGH: begin
          if (fc_finish) begin
            state_d = S_NEXT;
          end else if (wd == WD_LAST) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            wd_d = wd + 16'd1;
          end
        end
        S_NEXT: begin
          if (last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_LAUNCH;
            cur_d   = cur_layer + 2'd1;
            bank_d  = ~bank_sel;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      fc_start    <= 1'b0;
      cur_layer   <= '0;
      bank_sel    <= 1'b0;
      fc_in       <= '0;
      fc_out      <= '0;
      weight_base <= '0;
      bias_base   <= '0;
      wd          <= '0;
      n_q         <= '0;
    end else begin
      state       <= state_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      fc_start    <= start_d;
      cur_layer   <= cur_d;
      bank_sel    <= bank_d;
      fc_in       <= in_d;
      fc_out      <= out_d;
      weight_base <= wb_d;
      bias_base   <= bb_d;
      wd          <= wd_d;
      n_q         <= n_d;
    end
  end

  // table survives reset so a chain can be rerun without reprogramming
  always_ff @(posedge clk) begin
    if (cfg_we && (state == S_IDLE || state == S_ERROR)) begin
      t_in[cfg_idx]  <= cfg_fc_in;
      t_out[cfg_idx] <= cfg_fc_out;
      t_wb[cfg_idx]  <= cfg_w_base;
      t_bb[cfg_idx]  <= cfg_b_base;
    end
  end

endmodule
